// File: rtl/align_bw_mem_resp.sv
// ---------------------------------------------------------------------------
// align_bw_mem_resp
//
// Behavioural physical-memory end for the align_bw pseudo memory interface.
// Holds NUMVBNK banks of NUMSROW rows, each row NUMWRDS*WIDTH bits wide.
// Writes merge data under a per-bit enable mask. Reads return the row after
// SRAM_DELAY cycles through a fixed-latency pipeline with no backpressure.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset (clears the read pipeline only)
//   mem_write    write strobe
//   mem_wr_bnk   write bank
//   mem_wr_adr   write row
//   mem_wr_dwsn  write dwsn (accepted, no functional effect)
//   mem_bw       per-bit write enable
//   mem_din      write data
//   mem_read     read strobe
//   mem_rd_bnk   read bank
//   mem_rd_adr   read row
//   mem_rd_dwsn  read dwsn (accepted, no functional effect)
//   mem_rd_vld   read data valid, SRAM_DELAY cycles after mem_read
//   mem_rd_dout  read data (0 when mem_rd_vld=0)
//   mem_rd_fwrd  returned data includes a same-cycle write to the same row
//   mem_rd_padr  {bnk,adr} of the returned read
//   mem_rd_err   returned read, or a write issued with it, was out of range
// ---------------------------------------------------------------------------
module align_bw_mem_resp #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUMWRDS    = 4,
    parameter int unsigned BITWRDS    = 2,
    parameter int unsigned NUMVBNK    = 8,
    parameter int unsigned BITVBNK    = 3,
    parameter int unsigned NUMSROW    = 256,
    parameter int unsigned BITSROW    = 8,
    parameter int unsigned BITPADR    = 13,
    parameter int unsigned BITDWSN    = 4,
    parameter int unsigned SRAM_DELAY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_write,
    input  logic [BITVBNK-1:0]           mem_wr_bnk,
    input  logic [BITSROW-1:0]           mem_wr_adr,
    input  logic [BITDWSN-1:0]           mem_wr_dwsn,
    input  logic [NUMWRDS*WIDTH-1:0]     mem_bw,
    input  logic [NUMWRDS*WIDTH-1:0]     mem_din,
    input  logic                         mem_read,
    input  logic [BITVBNK-1:0]           mem_rd_bnk,
    input  logic [BITSROW-1:0]           mem_rd_adr,
    input  logic [BITDWSN-1:0]           mem_rd_dwsn,
    output logic                         mem_rd_vld,
    output logic [NUMWRDS*WIDTH-1:0]     mem_rd_dout,
    output logic                         mem_rd_fwrd,
    output logic [BITPADR-BITWRDS-1:0]   mem_rd_padr,
    output logic                         mem_rd_err
);

    localparam int unsigned DW    = NUMWRDS * WIDTH;
    localparam int unsigned BITRA = BITPADR - BITWRDS;
    // Rows are addressed as {bnk,adr}; only the first NUMVBNK banks are stored.
    localparam int unsigned MEMD  = NUMVBNK << BITSROW;

    typedef struct packed {
        logic             vld;
        logic [DW-1:0]    data;
        logic             fwrd;
        logic [BITRA-1:0] padr;
        logic             err;
    } stage_t;

    logic [DW-1:0]    mem_arr [MEMD];

    logic [BITRA-1:0] wr_idx;
    logic [BITRA-1:0] rd_idx;
    logic             wr_rng;
    logic             rd_rng;
    logic             wr_ok;
    logic [DW-1:0]    wr_merge;
    stage_t           s0;
    stage_t           pipe [SRAM_DELAY];

    logic             unused_dwsn;
    assign unused_dwsn = ^{mem_wr_dwsn, mem_rd_dwsn};

    assign wr_idx = {mem_wr_bnk, mem_wr_adr};
    assign rd_idx = {mem_rd_bnk, mem_rd_adr};

    // Widened compares keep the range check meaningful for non power-of-two sizes.
    assign wr_rng = (32'(mem_wr_bnk) < NUMVBNK) && (32'(mem_wr_adr) < NUMSROW);
    assign rd_rng = (32'(mem_rd_bnk) < NUMVBNK) && (32'(mem_rd_adr) < NUMSROW);
    assign wr_ok  = mem_write && wr_rng;

    assign wr_merge = (mem_arr[wr_idx] & ~mem_bw) | (mem_din & mem_bw);

    // Storage: not reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_arr[wr_idx] <= wr_merge;
        end
    end

    // Read capture: the row is sampled at the issuing edge; a same-row write
    // in that cycle is forwarded so the read sees the merged value.
    always_comb begin
        s0 = '0;
        if (mem_read) begin
            s0.vld  = 1'b1;
            s0.padr = rd_idx;
            if (!rd_rng) begin
                s0.err = 1'b1;
            end else if (wr_ok && (wr_idx == rd_idx)) begin
                s0.data = wr_merge;
                s0.fwrd = 1'b1;
            end else begin
                s0.data = mem_arr[rd_idx];
            end
            // An out-of-range write is only reportable through a read issued with it.
            if (mem_write && !wr_rng) begin
                s0.err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SRAM_DELAY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= s0;
            for (int unsigned i = 1; i < SRAM_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign mem_rd_vld  = pipe[SRAM_DELAY-1].vld;
    assign mem_rd_dout = pipe[SRAM_DELAY-1].data;
    assign mem_rd_fwrd = pipe[SRAM_DELAY-1].fwrd;
    assign mem_rd_padr = pipe[SRAM_DELAY-1].padr;
    assign mem_rd_err  = pipe[SRAM_DELAY-1].err;

endmodule

// File: tb/tb_align_bw_mem_resp.sv
module tb_align_bw_mem_resp;

    localparam int D = 2;

    typedef struct {
        logic         vld;
        logic [127:0] d;
        logic         fw;
        logic [10:0]  padr;
        logic         err;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_write;
    logic [2:0]   mem_wr_bnk;
    logic [7:0]   mem_wr_adr;
    logic [3:0]   mem_wr_dwsn;
    logic [127:0] mem_bw;
    logic [127:0] mem_din;
    logic         mem_read;
    logic [2:0]   mem_rd_bnk;
    logic [7:0]   mem_rd_adr;
    logic [3:0]   mem_rd_dwsn;

    logic         vld8, fw8, err8, vld6, fw6, err6;
    logic [127:0] dout8, dout6;
    logic [10:0]  padr8, padr6;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference storage and expected-response queues, one per instance
    logic [127:0] mm [2][2048];
    resp_t        q0[$];
    resp_t        q1[$];
    resp_t        zr;

    always #5 clk = ~clk;

    align_bw_mem_resp u_dut8 (
        .clk(clk), .rst(rst),
        .mem_write(mem_write), .mem_wr_bnk(mem_wr_bnk), .mem_wr_adr(mem_wr_adr),
        .mem_wr_dwsn(mem_wr_dwsn), .mem_bw(mem_bw), .mem_din(mem_din),
        .mem_read(mem_read), .mem_rd_bnk(mem_rd_bnk), .mem_rd_adr(mem_rd_adr),
        .mem_rd_dwsn(mem_rd_dwsn),
        .mem_rd_vld(vld8), .mem_rd_dout(dout8), .mem_rd_fwrd(fw8),
        .mem_rd_padr(padr8), .mem_rd_err(err8)
    );

    align_bw_mem_resp #(.NUMVBNK(6)) u_dut6 (
        .clk(clk), .rst(rst),
        .mem_write(mem_write), .mem_wr_bnk(mem_wr_bnk), .mem_wr_adr(mem_wr_adr),
        .mem_wr_dwsn(mem_wr_dwsn), .mem_bw(mem_bw), .mem_din(mem_din),
        .mem_read(mem_read), .mem_rd_bnk(mem_rd_bnk), .mem_rd_adr(mem_rd_adr),
        .mem_rd_dwsn(mem_rd_dwsn),
        .mem_rd_vld(vld6), .mem_rd_dout(dout6), .mem_rd_fwrd(fw6),
        .mem_rd_padr(padr6), .mem_rd_err(err6)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Spec rules applied directly: range check, merge, forwarding, error merging.
    task automatic model_issue(input int k, input logic wr, input logic [2:0] wb,
                               input logic [7:0] wa, input logic [127:0] bw,
                               input logic [127:0] din, input logic rd,
                               input logic [2:0] rb, input logic [7:0] ra,
                               output resp_t r);
        int unsigned nv;
        logic wok, rok;
        nv  = (k == 0) ? 8 : 6;
        wok = wr && (32'(wb) < nv);
        rok = rd && (32'(rb) < nv);
        r = zr;
        if (rd) begin
            r.vld  = 1'b1;
            r.padr = {rb, ra};
            if (!rok) begin
                r.err = 1'b1;
            end else begin
                r.d = mm[k][{rb, ra}];
                if (wok && ({wb, wa} == {rb, ra})) begin
                    r.d  = (r.d & ~bw) | (din & bw);
                    r.fw = 1'b1;
                end
            end
            if (wr && !wok) r.err = 1'b1;
        end
        if (wok) mm[k][{wb, wa}] = (mm[k][{wb, wa}] & ~bw) | (din & bw);
    endtask

    task automatic reset_queues();
        q0.delete();
        q1.delete();
        for (int i = 0; i < D - 1; i++) begin
            q0.push_back(zr);
            q1.push_back(zr);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vld8"}, {127'd0, vld8}, '0);
        check({tag, "_dout8"}, dout8, '0);
        check({tag, "_err8"}, {127'd0, err8}, '0);
        check({tag, "_vld6"}, {127'd0, vld6}, '0);
        check({tag, "_padr6"}, {117'd0, padr6}, '0);
    endtask

    // One clock: drive at negedge, clock, compare at the following negedge
    task automatic step(input logic wr, input logic [2:0] wb, input logic [7:0] wa,
                        input logic [127:0] bw, input logic [127:0] din,
                        input logic rd, input logic [2:0] rb, input logic [7:0] ra);
        resp_t r, e;
        mem_write   = wr;
        mem_wr_bnk  = wb;
        mem_wr_adr  = wa;
        mem_bw      = bw;
        mem_din     = din;
        mem_read    = rd;
        mem_rd_bnk  = rb;
        mem_rd_adr  = ra;
        mem_wr_dwsn = 4'($urandom);
        mem_rd_dwsn = 4'($urandom);
        model_issue(0, wr, wb, wa, bw, din, rd, rb, ra, r);
        q0.push_back(r);
        model_issue(1, wr, wb, wa, bw, din, rd, rb, ra, r);
        q1.push_back(r);
        @(posedge clk);
        @(negedge clk);
        e = q0.pop_front();
        check("vld8",  {127'd0, vld8}, {127'd0, e.vld});
        check("dout8", dout8, e.d);
        check("fwrd8", {127'd0, fw8}, {127'd0, e.fw});
        check("padr8", {117'd0, padr8}, {117'd0, e.padr});
        check("err8",  {127'd0, err8}, {127'd0, e.err});
        e = q1.pop_front();
        check("vld6",  {127'd0, vld6}, {127'd0, e.vld});
        check("dout6", dout6, e.d);
        check("fwrd6", {127'd0, fw6}, {127'd0, e.fw});
        check("padr6", {117'd0, padr6}, {117'd0, e.padr});
        check("err6",  {127'd0, err6}, {127'd0, e.err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        zr = '{vld: 1'b0, d: '0, fw: 1'b0, padr: '0, err: 1'b0};
        rst = 1'b0;
        mem_write = 1'b0; mem_wr_bnk = '0; mem_wr_adr = '0; mem_wr_dwsn = '0;
        mem_bw = '0; mem_din = '0;
        mem_read = 1'b0; mem_rd_bnk = '0; mem_rd_adr = '0; mem_rd_dwsn = '0;
        reset_queues();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b1;

        // Preload every row so reads never see uninitialised storage
        for (int b = 0; b < 8; b++)
            for (int a = 0; a < 256; a++)
                step(1'b1, 3'(b), 8'(a), '1, rand128(), 1'b0, '0, '0);
        idle(D);

        // Full write then read of bnk 2 adr 5
        step(1'b1, 3'd2, 8'd5, '1, '1, 1'b0, '0, '0);
        step(1'b0, '0, '0, '0, '0, 1'b1, 3'd2, 8'd5);
        idle(D);

        // Masked write over a zeroed row
        step(1'b1, 3'd0, 8'd0, '1, '0, 1'b0, '0, '0);
        step(1'b1, 3'd0, 8'd0, {4{32'h0000FFFF}}, {4{32'hAAAAAAAA}}, 1'b0, '0, '0);
        step(1'b0, '0, '0, '0, '0, 1'b1, 3'd0, 8'd0);
        idle(D);

        // Same-cycle write and read, top corner row (out of range for the 6-bank copy)
        step(1'b1, 3'd7, 8'd255, '1, '0, 1'b0, '0, '0);
        step(1'b1, 3'd7, 8'd255, {96'd0, 32'hFFFFFFFF}, {96'd0, 32'h12345678},
             1'b1, 3'd7, 8'd255);
        idle(D);

        // Back-to-back reads of preloaded rows
        for (int i = 0; i < 10; i++) step(1'b1, 3'd1, 8'(i), '1, 128'(i), 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, '0, '0, 1'b1, 3'd1, 8'(i));
        idle(D);

        // Write right after a read of the same row does not disturb it
        step(1'b0, '0, '0, '0, '0, 1'b1, 3'd4, 8'd3);
        step(1'b1, 3'd4, 8'd3, '1, rand128(), 1'b0, '0, '0);
        idle(D);

        // Out-of-range read, and out-of-range write alongside an in-range read
        step(1'b0, '0, '0, '0, '0, 1'b1, 3'd6, 8'd9);
        step(1'b1, 3'd7, 8'd1, '1, rand128(), 1'b1, 3'd0, 8'd1);
        step(1'b1, 3'd6, 8'd2, '1, rand128(), 1'b0, '0, '0);
        idle(D);

        // Reset one cycle after a read: it must never come out
        step(1'b1, 3'd3, 8'd7, '1, rand128(), 1'b0, '0, '0);
        step(1'b0, '0, '0, '0, '0, 1'b1, 3'd3, 8'd7);
        rst = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        for (int i = 0; i < D + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_zero_outputs("in_rst");
        end
        reset_queues();
        rst = 1'b1;
        step(1'b0, '0, '0, '0, '0, 1'b1, 3'd3, 8'd7);
        idle(D);

        // Randomized traffic over a small row set to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            logic [127:0] bw;
            int sel;
            sel = $urandom_range(0, 3);
            bw  = (sel == 0) ? '0 : (sel == 1) ? '1 : rand128();
            step(1'($urandom), 3'($urandom), 8'($urandom_range(0, 7)), bw, rand128(),
                 1'($urandom), 3'($urandom), 8'($urandom_range(0, 7)));
        end
        idle(D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
